alu_issue: RTL

ALU_ISSUE -- requirements
Module: alu_issue

---
 rtl/alu_issue.sv | 111 +++++++++++
 1 files changed

// File: rtl/alu_issue.sv
// Single-outstanding issue stage between a requester and an external ALU.
// Packs the instruction word, screens illegal operations and returns one response per request.
module alu_issue (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_cls,
    input  logic [3:0]  req_func,
    input  logic [3:0]  req_a,
    input  logic [3:0]  req_b,
    output logic [15:0] alu_inp,
    input  logic [15:0] alu_out,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_data,
    output logic        rsp_err,
    output logic [7:0]  issue_cnt,
    output logic [7:0]  err_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    localparam logic [15:0] REJECT_WORD = 16'hAFFF;

    state_t      state_q;
    logic [15:0] aluInp_q;
    logic [15:0] rspData_q;
    logic        rspErr_q;
    logic [7:0]  issueCnt_q;
    logic [7:0]  errCnt_q;
    logic        reject_q;
    logic        opErr_q;

    logic        legalFunc;
    logic        divZero;
    logic        opErr_d;
    logic        execErr_d;
    logic [15:0] rspData_d;
    logic [7:0]  errCnt_d;

    always_comb begin
        legalFunc = 1'b0;
        case (req_func)
            4'hF, 4'hE, 4'hD, 4'hC, 4'h1,
            4'h2, 4'hA, 4'hB, 4'h8, 4'h9: legalFunc = 1'b1;
            default:                      legalFunc = 1'b0;
        endcase
    end

    // Divide-by-zero never reaches the ALU; its response is synthesised locally.
    assign divZero   = (req_cls == 2'd0) && (req_func == 4'h2) && (req_b == 4'h0);
    assign opErr_d   = (req_cls != 2'd0) || !legalFunc;
    assign rspData_d = reject_q ? REJECT_WORD : alu_out;
    assign execErr_d = reject_q || opErr_q || (alu_out == REJECT_WORD);
    assign errCnt_d  = (errCnt_q == 8'hFF) ? errCnt_q : errCnt_q + 8'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            aluInp_q   <= 16'h0000;
            rspData_q  <= 16'h0000;
            rspErr_q   <= 1'b0;
            issueCnt_q <= 8'h00;
            errCnt_q   <= 8'h00;
            reject_q   <= 1'b0;
            opErr_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        reject_q   <= divZero;
                        opErr_q    <= opErr_d;
                        issueCnt_q <= issueCnt_q + 8'd1;
                        if (!divZero) begin
                            aluInp_q <= {req_cls, 2'b00, req_a, req_b, req_func};
                        end
                        state_q <= EXEC;
                    end
                end
                EXEC: begin
                    rspData_q <= rspData_d;
                    rspErr_q  <= execErr_d;
                    if (execErr_d) begin
                        errCnt_q <= errCnt_d;
                    end
                    state_q <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign alu_inp   = aluInp_q;
    assign rsp_data  = rspData_q;
    assign rsp_err   = rspErr_q;
    assign issue_cnt = issueCnt_q;
    assign err_cnt   = errCnt_q;

endmodule
